mips_regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the MIPS datapath; replaces the fixed 2-read/1-write file.

---
 rtl/mips_regfile_mp_if.sv | 30 +++
 rtl/mips_regfile_mp.sv | 118 +++++++++++
 tb/tb_mips_regfile_mp.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_mp_if
// Brief    : Bus bundle between decode/writeback and the multi-port regfile.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     clr_req;
    logic                     busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_mp
// Brief    : Parametrised N-read/1-write register file with optional bypass,
//            hardwired zero entry and a one-entry-per-cycle clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mips_regfile_mp_if.slave bus
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
    logic                r_busy, w_busy_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic                w_wr_ok;

    // A user write survives only if no clear is requested and it does not target the zero entry.
    assign w_wr_ok = bus.wr_en && !bus.clr_req &&
                     !((ZERO_REG != 0) && (bus.wr_addr == '0));

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy_nxt    = r_busy;
        w_mem_we      = 1'b0;
        w_mem_addr    = bus.wr_addr;
        w_mem_data    = bus.wr_data;
        case (r_state)
            IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                end else if (w_wr_ok) begin
                    w_mem_we = 1'b1;
                end
            end
            CLEAR: begin
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_cnt;
                w_mem_data    = '0;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == C_LAST) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Storage is never reset directly; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign bus.busy = r_busy;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;

            assign w_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

            always_comb begin
                w_data = r_mem[w_addr];
                if (r_state == CLEAR) begin
                    w_data = '0;
                end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                end else if ((BYPASS != 0) && bus.wr_en && !bus.clr_req &&
                             (bus.wr_addr == w_addr)) begin
                    w_data = bus.wr_data;
                end
            end

            assign bus.rd_data[i*DATA_W +: DATA_W] = w_data;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_mp
// Brief    : Bench for two builds: 32x32/2-port/bypass/zero-reg and
//            8x32/4-port/no-bypass/no-zero-reg, against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_mp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    mips_regfile_mp_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) ifb ();

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    mips_regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: architectural contents plus remaining sweep cycles per build.
    logic [31:0] mem [2][32];
    int          left [2];
    logic        s_wr_en [2];
    logic [4:0]  s_wr_addr [2];
    logic [31:0] s_wr_data [2];
    logic        s_clr [2];
    logic [4:0]  s_rd [2][4];

    function automatic int depth(int d);   return (d == 0) ? 32 : 8; endfunction
    function automatic int nrd(int d);     return (d == 0) ? 2 : 4;  endfunction
    function automatic bit byp(int d);     return d == 0;            endfunction
    function automatic bit zr(int d);      return d == 0;            endfunction

    function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
        if (left[d] > 0)                                   return 32'h0;
        if (zr(d) && a == 5'd0)                            return 32'h0;
        if (byp(d) && s_wr_en[d] && !s_clr[d] && s_wr_addr[d] == a) return s_wr_data[d];
        return mem[d][a];
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic apply();
        ifa.wr_en   = s_wr_en[0];
        ifa.wr_addr = s_wr_addr[0];
        ifa.wr_data = s_wr_data[0];
        ifa.clr_req = s_clr[0];
        ifa.rd_addr = {s_rd[0][1], s_rd[0][0]};
        ifb.wr_en   = s_wr_en[1];
        ifb.wr_addr = s_wr_addr[1][2:0];
        ifb.wr_data = s_wr_data[1];
        ifb.clr_req = s_clr[1];
        ifb.rd_addr = {s_rd[1][3][2:0], s_rd[1][2][2:0], s_rd[1][1][2:0], s_rd[1][0][2:0]};
    endtask

    task automatic check(string tag);
        for (int p = 0; p < nrd(0); p++)
            cmp($sformatf("%s A.rd%0d[%0d]", tag, p, s_rd[0][p]), ifa.rd_data[p*32 +: 32], exp_rd(0, s_rd[0][p]));
        for (int p = 0; p < nrd(1); p++)
            cmp($sformatf("%s B.rd%0d[%0d]", tag, p, s_rd[1][p]), ifb.rd_data[p*32 +: 32], exp_rd(1, s_rd[1][p]));
        cmp({tag, " A.busy"}, {31'b0, ifa.busy}, (left[0] > 0) ? 32'd1 : 32'd0);
        cmp({tag, " B.busy"}, {31'b0, ifb.busy}, (left[1] > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                left[d] = depth(d);
            end else if (left[d] > 0) begin
                left[d]--;
                if (left[d] == 0)
                    for (int a = 0; a < 32; a++) mem[d][a] = 32'h0;
            end else if (s_clr[d]) begin
                left[d] = depth(d);
            end else if (s_wr_en[d] && !(zr(d) && s_wr_addr[d] == 5'd0)) begin
                mem[d][s_wr_addr[d]] = s_wr_data[d];
            end
        end
        #1;
    endtask

    task automatic step(string tag);
        apply();
        @(negedge clk);
        check(tag);
        tick();
    endtask

    task automatic quiet();
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d] = 1'b0;
            s_clr[d]   = 1'b0;
        end
    endtask

    task automatic rand_in(bit allow_wr);
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d]   = allow_wr && ($urandom_range(0, 1) == 1);
            s_wr_addr[d] = 5'($urandom_range(0, depth(d) - 1));
            s_wr_data[d] = $urandom;
            s_clr[d]     = 1'b0;
            for (int p = 0; p < 4; p++)
                s_rd[d][p] = ($urandom_range(0, 2) == 0) ? s_wr_addr[d]
                                                         : 5'($urandom_range(0, depth(d) - 1));
        end
    endtask

    task automatic read_all(string tag);
        quiet();
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) begin
                s_rd[0][p] = 5'(a);
                s_rd[1][p] = 5'(a % 8);
            end
            step(tag);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            left[d] = 0;
            for (int a = 0; a < 32; a++) mem[d][a] = 32'h0;
            for (int p = 0; p < 4; p++) s_rd[d][p] = 5'd0;
            s_wr_addr[d] = 5'd0;
            s_wr_data[d] = 32'h0;
        end
        quiet();
        apply();

        // Reset, then sweep with random (ignored) writes.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 33; c++) begin
            rand_in(1'b1);
            step("rst_sweep");
        end
        read_all("post_reset");

        // Write then read back on all ports.
        quiet();
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d] = 1'b1; s_wr_addr[d] = 5'd5; s_wr_data[d] = 32'hDEADBEEF;
        end
        step("wr_r5");
        quiet();
        for (int d = 0; d < 2; d++) for (int p = 0; p < 4; p++) s_rd[d][p] = 5'd5;
        step("rd_r5");

        // Same-cycle bypass versus stored value.
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d] = 1'b1; s_wr_addr[d] = 5'd7; s_wr_data[d] = 32'h12345678;
            s_rd[d][0] = 5'd5; s_rd[d][1] = 5'd7;
        end
        step("bypass_r7");
        quiet();
        step("after_r7");

        // Zero entry write.
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d] = 1'b1; s_wr_addr[d] = 5'd0; s_wr_data[d] = 32'hFFFFFFFF;
            for (int p = 0; p < 4; p++) s_rd[d][p] = 5'd0;
        end
        step("wr_r0");
        quiet();
        step("rd_r0");

        // Fill, then clear with a colliding write to r3.
        for (int a = 0; a < 32; a++) begin
            for (int d = 0; d < 2; d++) begin
                s_wr_en[d] = 1'b1; s_wr_addr[d] = 5'(a % depth(d));
                s_wr_data[d] = $urandom | 32'h1;
                s_rd[d][0] = s_wr_addr[d]; s_rd[d][1] = 5'd3;
            end
            step("fill");
        end
        for (int d = 0; d < 2; d++) begin
            s_wr_en[d] = 1'b1; s_wr_addr[d] = 5'd3; s_wr_data[d] = 32'hA5A5A5A5;
            s_clr[d] = 1'b1; s_rd[d][0] = 5'd3; s_rd[d][1] = 5'd2;
        end
        step("clr_req");
        for (int c = 0; c < 33; c++) begin
            rand_in(1'b1);
            step("clr_sweep");
        end
        read_all("post_clr");

        // Reset at sweep cycle 10 restarts the sweep.
        quiet();
        for (int d = 0; d < 2; d++) s_clr[d] = 1'b1;
        step("clr_req2");
        quiet();
        for (int c = 0; c < 10; c++) begin
            rand_in(1'b1);
            step("sweep_pre");
        end
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        for (int c = 0; c < 33; c++) begin
            rand_in(1'b1);
            step("sweep_restart");
        end

        // Random traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            rand_in(1'b1);
            for (int d = 0; d < 2; d++) s_clr[d] = ($urandom_range(0, 49) == 0);
            step("random");
        end
        read_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
